// File: rtl/uart_pkg.sv
// Shared UART transmit types and frame constants.
// The optional parity bit is selected with UART_TX_PARITY_EN.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
endpackage

// File: rtl/uart_word_tx_if.sv
// Word-level request/status bundle between a result producer and uart_word_tx.
interface uart_word_tx_if #(parameter int NUM_BYTES = 4);
  logic [8*NUM_BYTES-1:0] data_in;
  logic                   wr_en;
  logic                   Tx_busy;
  logic                   done;

  modport master (output data_in, wr_en, input Tx_busy, done);
  modport slave  (input data_in, wr_en, output Tx_busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// Per-byte frame sequencer: start, 8 LSB-first data bits, optional even parity
// (UART_TX_PARITY_EN), stop; chains straight into the next byte when not last.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 byte_load,
  input  logic                 byte_last,
  input  logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_done,
  output logic                 Tx
);
  tx_state_t            state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 tx_q, tx_d;
  logic                 stop_q, stop_d;  // stop bit already on the line
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign Tx = tx_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      tx_q      <= IDLE_LEVEL;
      stop_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      tx_q      <= tx_d;
      stop_q    <= stop_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    tx_d      = tx_q;
    stop_d    = stop_q;
    byte_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (byte_load) begin
          sr_d    = byte_data;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^byte_data;
`endif
        end
      end
      START: if (clken) begin
        tx_d      = 1'b0;
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: if (clken) begin
        tx_d      = sr_q[0];
        sr_d      = sr_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(DATA_BITS-1))
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (clken) begin
        tx_d    = par_q;
        state_d = STOP;
      end
`endif
      STOP: if (clken) begin
        if (!stop_q) begin
          tx_d   = IDLE_LEVEL;
          stop_d = 1'b1;
        end else begin
          stop_d    = 1'b0;
          byte_done = 1'b1;
          if (byte_last) begin
            state_d = IDLE;
          end else begin
            // next start bit begins on the same tick the stop bit ends
            tx_d      = 1'b0;
            sr_d      = byte_data;
            bit_cnt_d = '0;
            state_d   = DATA;
`ifdef UART_TX_PARITY_EN
            par_d     = ^byte_data;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_word_tx.sv
// Sends a NUM_BYTES-byte word LSB byte first as back-to-back UART frames.
// Parity frames are enabled by defining UART_TX_PARITY_EN.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int   NUM_BYTES  = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic          clken,
  uart_word_tx_if.slave bus,
  output logic          Tx
);
  localparam int W  = 8*NUM_BYTES;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES-1);

  // shift_reg holds the bytes not yet handed to the byte sequencer
  logic [W-1:0]         shift_reg;
  logic [CW-1:0]        byte_cnt;
  logic                 busy_q, done_q;
  logic                 accept, byte_last, byte_done;
  logic [DATA_BITS-1:0] byte_data;

  assign accept      = bus.wr_en && !busy_q;
  assign byte_last   = (byte_cnt == LAST);
  assign byte_data   = busy_q ? shift_reg[DATA_BITS-1:0] : bus.data_in[DATA_BITS-1:0];
  assign bus.Tx_busy = busy_q;
  assign bus.done    = done_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= byte_done && byte_last;
      if (accept) begin
        shift_reg <= bus.data_in >> 8;
        byte_cnt  <= '0;
        busy_q    <= 1'b1;
      end else if (byte_done) begin
        if (byte_last) begin
          busy_q <= 1'b0;
        end else begin
          byte_cnt  <= byte_cnt + 1'b1;
          shift_reg <= shift_reg >> 8;
        end
      end
    end
  end

  uart_tx_byte #(.IDLE_LEVEL(IDLE_LEVEL)) u_byte (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .clken     (clken),
    .byte_load (accept),
    .byte_last (byte_last),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .Tx        (Tx)
  );
endmodule
